// File: rtl/div8by4_unsigned_seq_if.sv
// Start/Done handshake and operand/result bundle for the 8-by-4 unsigned divider.
// The master drives a request; the slave (the divider) returns results and status.
interface div8by4_unsigned_seq_if;
  logic       Start;
  logic [7:0] Dividend;
  logic [3:0] Divisor;
  logic [7:0] Quotient;
  logic [3:0] Remainder;
  logic       Done;
  logic       Busy;
  logic       DivByZero;

  modport master (
    output Start, Dividend, Divisor,
    input  Quotient, Remainder, Done, Busy, DivByZero
  );

  modport slave (
    input  Start, Dividend, Divisor,
    output Quotient, Remainder, Done, Busy, DivByZero
  );
endinterface

// File: rtl/div8by4_unsigned_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider.
// One quotient bit is resolved per clock with a single trial subtractor.
// Eight iterations follow a Start.
// A zero divisor completes immediately with Quotient=FF and the DivByZero flag set.
module div8by4_unsigned_seq (
  input  logic                         clk,
  input  logic                         rst_n,
  div8by4_unsigned_seq_if.slave        bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q;
  logic [7:0] q_q;          // quotient shift register, dividend bits shift out the top
  logic [7:0] q_d;
  logic [4:0] r_q;          // partial remainder
  logic [4:0] r_d;
  logic [3:0] d_q;          // captured divisor
  logic [2:0] cnt_q;        // iteration counter, last iteration when 7
  logic [7:0] quotient_q;
  logic [3:0] remainder_q;
  logic       done_q;
  logic       busy_q;
  logic       dbz_q;

  logic [5:0] s_s;          // shifted partial remainder, widened by r_q[4]
  logic [5:0] t_s;          // trial difference, bit 5 is the borrow/sign

  // One restoring step: shift in the next dividend bit and try to subtract the divisor.
  // r_q[4] is always 0 between iterations, because the remainder stays below the divisor.
  // Because of that, including it as the top bit of S does not change the result.
  always_comb begin
    s_s = {r_q, q_q[7]};
    t_s = s_s - {2'b00, d_q};
    if (t_s[5] == 1'b0) begin
      r_d = t_s[4:0];
      q_d = {q_q[6:0], 1'b1};
    end else begin
      r_d = s_s[4:0];
      q_d = {q_q[6:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and registered result/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      q_q         <= 8'h00;
      r_q         <= 5'h00;
      d_q         <= 4'h0;
      cnt_q       <= 3'd0;
      quotient_q  <= 8'h00;
      remainder_q <= 4'h0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.Start) begin
            q_q   <= bus.Dividend;
            d_q   <= bus.Divisor;
            r_q   <= 5'h00;
            cnt_q <= 3'd0;
            if (bus.Divisor != 4'h0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end else begin
              // Divide by zero completes on the sampling edge without iterating.
              quotient_q  <= 8'hFF;
              remainder_q <= 4'h0;
              dbz_q       <= 1'b1;
              done_q      <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_RUN: begin
          q_q   <= q_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            quotient_q  <= q_d;
            remainder_q <= r_d[3:0];
            dbz_q       <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Quotient  = quotient_q;
  assign bus.Remainder = remainder_q;
  assign bus.Done      = done_q;
  assign bus.Busy      = busy_q;
  assign bus.DivByZero = dbz_q;

endmodule
